fifo_rv: RTL
============

# fifo_rv

Synchronous valid/ready FIFO that sits directly downstream of the round-robin N-to-1 arbiter. It absorbs the merged stream so a stalled consumer does not immediately back-pressure every arbitrated input. It also decouples the consumer's `out_ready` from the arbiter's grant path. Storage is a circular buffer with first-word-fall-through output; no combinational path exists from `out_ready` to `in_ready`.

## Interface
- `DWIDTH`, 16, payload width in bits; matches arbiter `DWIDTH`.
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `CWIDTH`, `$clog2(DEPTH)+1`, width of occupancy count; derived, not overridden.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — reset, synchronous, active-low (asserted when 0).
- `in_valid` in 1 — producer (arbiter `out_valid`) has data.
- `in_data` in DWIDTH — producer payload.
- `in_ready` out 1 — FIFO accepts; feeds arbiter `out_ready`.
- `out_valid` out 1 — head entry available.
- `out_data` out DWIDTH — head entry payload.
- `out_ready` in 1 — consumer accepts head.
- `count` out CWIDTH — current occupancy, 0..DEPTH.
- `hwm` out CWIDTH — peak occupancy since reset; present only with `FIFO_HWM_EN`.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Empty: `wr_ptr == rd_ptr`.
  - Full: low bits equal and wrap bits differ.
- Push: `in_valid & in_ready` → `mem[wr_ptr]` ← `in_data`, `wr_ptr` +1 (mod 2·DEPTH).
- Pop: `out_valid & out_ready` → `rd_ptr` +1.
- `in_ready = rst & ~full`.
  - Depends only on registered state. When full, no push is accepted even if a pop occurs that cycle.
- `out_valid = rst & ~empty`.
- `out_data = mem[rd_ptr]` when `out_valid`, else all-zero.
- `count` is a registered counter: +1 on push only, −1 on pop only, unchanged on both or neither. It always equals `wr_ptr − rd_ptr`.
- Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→EMPTY on pop-only at count=1.
  - PARTIAL→FULL on push-only at count=DEPTH−1.
  - FULL→PARTIAL on pop.
  - All other cases hold.
- Simultaneous push+pop in PARTIAL: both occur; count unchanged; head advances.
- Simultaneous push+pop in EMPTY: pop is impossible (`out_valid`=0); push only.
- Wrap-around: pointers wrap modulo 2·DEPTH; data ordering is strictly FIFO across the wrap.
- Reset (`rst`=0 at an edge):
  - `wr_ptr`, `rd_ptr`, `count` (and `hwm`) go to 0.
  - `in_ready`=0, `out_valid`=0, `out_data`=0 while `rst`=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries; a handshake in the reset cycle has no effect.

## Timing
- Write-to-read latency is 1 cycle. Data pushed at edge k is visible on `out_data` with `out_valid`=1 in the cycle following edge k.
- Pop takes effect at the edge; the next head is presented in the following cycle.
- `in_ready` rises the cycle after a pop from FULL.
- Throughput is 1 entry/cycle sustained when neither side stalls.
- First cycle after reset release: `in_ready`=1, `out_valid`=0, `count`=0.

## Configuration
- `FIFO_HWM_EN` defined:
  - Adds port `hwm` and a register updated each cycle to `max(hwm, next count)`.
  - Reset to 0; saturates at DEPTH; never decreases except on reset.
- Not defined: no `hwm` port and no register; all other behaviour is identical.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles → `in_ready`=0, `out_valid`=0, `out_data`=0. After release → `in_ready`=1, `count`=0.
- Fill and drain, DEPTH=4, `out_ready`=0:
  - Push 0x0001..0x0004 → `count`=4, `in_ready`=0; a fifth push of 0x0005 is refused.
  - Set `out_ready`=1 → 0x0001..0x0004 emerge in order, one per cycle; `count` ends at 0.
- Full with simultaneous pop: at FULL, `in_valid`=1 and `out_ready`=1 in the same cycle → pop only, `count`=3. `in_ready`=1 the next cycle.
- Streaming wrap: `in_valid`=`out_ready`=1 for 20 cycles with incrementing data from 0x0010 → output is 0x0010..0x0023 in order, `count` stays 1, no drops or duplicates.
- Reset mid-operation: push 3 entries, assert `rst` for 1 cycle → `count`=0, `out_valid`=0; the next push of 0xBEEF is the first word out.
- With `FIFO_HWM_EN`: push 3, pop 3, push 1 → `hwm`=3, `count`=1; after reset, `hwm`=0.

Source files
------------

// File: rtl/fifo_rv_if.sv
// Valid/ready handshake bundle between the arbiter, fifo_rv and the consumer.
// With FIFO_HWM_EN defined the bundle also carries the occupancy high-water mark.
interface fifo_rv_if #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
);
  localparam int CWIDTH = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic [CWIDTH-1:0] count;
`ifdef FIFO_HWM_EN
  logic [CWIDTH-1:0] hwm;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, count, hwm);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, count, hwm);
`else
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, count);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, count);
`endif
endinterface

// File: rtl/fifo_rv.sv
// First-word-fall-through circular-buffer FIFO for the arbiter output stream.
// Optional FIFO_HWM_EN adds a peak-occupancy register on bus.hwm.
module fifo_rv #(
  parameter  int DWIDTH = 16,
  parameter  int DEPTH  = 4,
  localparam int CWIDTH = $clog2(DEPTH) + 1
) (
  input  logic      clk,
  input  logic      rst,
  fifo_rv_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [CWIDTH-1:0] r_count, w_count_nxt;
  logic              w_full, w_empty, w_push, w_pop;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // in_ready looks only at registered state, so out_ready never reaches it.
  assign bus.in_ready  = rst & ~w_full;
  assign bus.out_valid = rst & ~w_empty;
  assign bus.out_data  = bus.out_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign bus.count     = r_count;

  assign w_push = bus.in_valid  & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CWIDTH'(1);
      2'b01:   w_count_nxt = r_count - CWIDTH'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_count <= w_count_nxt;
    end
  end

  // Storage is not reset; w_push is already gated off while rst is low.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
  end

`ifdef FIFO_HWM_EN
  logic [CWIDTH-1:0] r_hwm;

  always_ff @(posedge clk) begin
    if (!rst)                    r_hwm <= '0;
    else if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
  end

  assign bus.hwm = r_hwm;
`endif
endmodule
